uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit stage that sits directly downstream of the baud-rate tick generator in the UART-TX path.
- Accepts a parallel byte on a start strobe and frames it as start bit, data LSB-first, optional parity, and stop bit(s).
- Drives the serial line, timing every bit from the 16x oversample tick.
- Gates the tick generator through its own enable output, so the generator only runs while a frame is in flight.

Parameters:
- DATA_BITS, 8, number of data bits per frame (legal 5..9).
- SB_TICKS, 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, with PARITY_EN=1: 0 selects even parity, 1 selects odd.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- s_tick  input  1  16x oversample tick: the baud generator's done output, one clk wide.
- tx_start  input  1  request strobe; sampled only in IDLE.
- din  input  DATA_BITS  byte to send; captured in the cycle tx_start is accepted.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high whenever the FSM is not in IDLE.
- tx_done_tick  output  1  one-cycle pulse marking frame completion.
- baud_en  output  1  enable for the baud generator; equals tx_busy.

Behaviour:
- Reset (synchronous, overrides everything, legal mid-frame):
  - state=IDLE, tick_cnt=0, bit_cnt=0.
  - tx=1, tx_busy=0, baud_en=0, tx_done_tick=0.
  - A mid-frame reset aborts the frame; tx is 1 after that edge and no done pulse is produced.
- Internal state:
  - tick_cnt: 5 bits, counts oversample ticks within one bit.
  - bit_cnt: counts data bits, sized for DATA_BITS-1.
  - shreg: DATA_BITS wide.
  - par: parity bit, computed as XOR-reduce(din) XOR PARITY_ODD at capture.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_start=1: shreg<=din, compute par, tick_cnt<=0, go to START.
  - tx is 0 from the first cycle after the accepting edge.
- START:
  - tx=0.
  - On s_tick: if tick_cnt==15, set tick_cnt<=0, bit_cnt<=0, go to DATA; otherwise tick_cnt+1.
- DATA:
  - tx=shreg[0].
  - On s_tick with tick_cnt==15: tick_cnt<=0, shreg shifts right by 1.
  - If bit_cnt==DATA_BITS-1, go to PARITY when PARITY_EN=1, otherwise STOP; else bit_cnt+1.
- PARITY (only reachable when PARITY_EN=1):
  - tx=par.
  - After 16 ticks go to STOP with tick_cnt<=0.
- STOP:
  - tx=1.
  - On s_tick with tick_cnt==SB_TICKS-1: go to IDLE, tick_cnt<=0, and register tx_done_tick<=1 for exactly one cycle.
  - In that cycle tx_busy=0.
- Ticks and counters:
  - Cycles without s_tick hold all counters.
  - tick_cnt never exceeds its bit's terminal value.
  - s_tick seen in IDLE has no effect.
- Frame length:
  - (1 + DATA_BITS + PARITY_EN)*16 + SB_TICKS ticks from the first tick after acceptance.
  - Each bit holds exactly 16 ticks on tx; the stop bit holds SB_TICKS.
- tx_start rules:
  - Ignored in every state other than IDLE; din may change freely after capture.
  - tx_start high in the tx_done_tick cycle (state is already IDLE) is accepted, giving a back-to-back frame with no idle gap beyond the stop bit.
  - tx_start high on the STOP-exit edge is ignored.
- baud_en is derived combinationally from the state (state != IDLE).
- tx and tx_done_tick are registered outputs, glitch-free.

Test Plan:
1. Reset, then s_tick every 4 clk with DATA_BITS=8, PARITY_EN=0.
   - Stimulus: tx_start with din=8'hA5.
   - Required: tx holds 0 for 16 ticks, then data bits 1,0,1,0,0,1,0,1, each 16 ticks.
   - Then stop=1 for 16 ticks, one tx_done_tick, and tx_busy/baud_en low afterwards.
   - Total 160 ticks.
2. PARITY_EN=1, PARITY_ODD=0, din=8'h07.
   - Required: parity bit=1 after the data bits; with PARITY_ODD=1, parity bit=0.
   - Frame is 176 ticks.
3. tx_start pulsed with din=8'h3C during the DATA state of an 8'hFF frame.
   - Required: ignored; the line carries 8'hFF only and exactly one tx_done_tick follows.
4. tx_start held high through the tx_done_tick cycle with new din=8'h5A.
   - Required: next start bit begins the following cycle; two done pulses exactly 160 ticks apart.
5. rst asserted for 1 clk at bit_cnt=3 of DATA.
   - Required: next cycle tx=1, tx_busy=0, no done pulse.
   - A fresh tx_start afterwards sends a full correct frame.
6. SB_TICKS=32 with s_tick tied high every cycle.
   - Required: stop bit lasts 32 cycles, start and data bits 16 cycles each, and the frame is correct.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel word as start, LSB-first data, optional parity and
// stop bits, timing each bit from a 16x oversample tick and gating the baud generator.
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned SB_TICKS   = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick,
    output logic                 baud_en
);

    localparam int unsigned BitCntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_BITS - 1);
    localparam logic [4:0] TickLast = 5'd15;
    localparam logic [4:0] StopLast = 5'(SB_TICKS - 1);
    localparam logic ParOdd = (PARITY_ODD != 0);
    localparam logic ParEn  = (PARITY_EN != 0);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..9");
    end
    if (SB_TICKS < 1 || SB_TICKS > 32) begin : gen_bad_sb_ticks
        $error("uart_tx_serializer: SB_TICKS must fit the 5-bit tick counter");
    end

    logic [2:0]           state_q, state_d;
    logic [4:0]           tick_cnt_q, tick_cnt_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (tx_start) begin
                    shreg_d    = din;
                    par_d      = (^din) ^ ParOdd;
                    tick_cnt_d = 5'd0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = 5'd0;
                        bit_cnt_d  = '0;
                        state_d    = StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = 5'd0;
                        shreg_d    = shreg_q >> 1;
                        if (bit_cnt_q == BitLast) begin
                            state_d = ParEn ? StParity : StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitCntW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end
            StParity: begin
                if (s_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = 5'd0;
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (tick_cnt_q == StopLast) begin
                        tick_cnt_d = 5'd0;
                        state_d    = StIdle;
                        done_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                tick_cnt_d = 5'd0;
            end
        endcase
    end

    // Line level is decoded from the next state so tx is a plain flop with no output glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= 5'd0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = (state_q != StIdle);
    assign baud_en      = tx_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: default, even/odd parity and 2-stop-bit instances.
module tb_uart_tx_serializer;

    logic clk;
    logic rst;
    logic s_tick;
    logic tick_hi;
    logic start0, start1, start3;
    logic [7:0] din0, din1, din3;
    logic tx0, busy0, done0, ben0;
    logic tx1, busy1, done1, ben1;
    logic tx2, busy2, done2, ben2;
    logic tx3, busy3, done3, ben3;

    int total = 0;
    int passed = 0;
    int failed = 0;

    logic samp0[$];
    logic samp1[$];
    logic samp2[$];
    logic samp3[$];
    int   done_ticks0[$];
    int   tick_ctr = 0;
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;
    int   done_cnt2 = 0;
    int   done_cnt3 = 0;

    uart_tx_serializer u_dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start0), .din(din0),
        .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0), .baud_en(ben0)
    );

    uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start1), .din(din1),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1), .baud_en(ben1)
    );

    uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start1), .din(din1),
        .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2), .baud_en(ben2)
    );

    uart_tx_serializer #(.SB_TICKS(32)) u_sb32 (
        .clk(clk), .rst(rst), .s_tick(tick_hi), .tx_start(start3), .din(din3),
        .tx(tx3), .tx_busy(busy3), .tx_done_tick(done3), .baud_en(ben3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: one clk wide, every fourth cycle.
    initial begin
        int div;
        div = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    // Records the line level once per consumed tick while each instance is busy.
    always @(negedge clk) begin
        if (s_tick) tick_ctr++;
        if (s_tick && busy0) samp0.push_back(tx0);
        if (s_tick && busy1) samp1.push_back(tx1);
        if (s_tick && busy2) samp2.push_back(tx2);
        if (busy3) samp3.push_back(tx3);
        if (done0) begin
            done_cnt0++;
            done_ticks0.push_back(tick_ctr);
        end
        if (done1) done_cnt1++;
        if (done2) done_cnt2++;
        if (done3) done_cnt3++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One bit slot: all len samples must agree and equal exp; disagreement reads as x.
    task automatic check_slot(input string tag, input logic q[$], input int pos, input int len,
                              input logic exp);
        logic v;
        v = (pos < q.size()) ? q[pos] : 1'bx;
        for (int i = 1; i < len; i++) begin
            if (pos + i >= q.size() || q[pos + i] !== v) v = 1'bx;
        end
        check1(tag, v, exp);
    endtask

    task automatic check_frame(input string tag, input logic q[$], input int base,
                               input logic [7:0] data, input bit par_en, input logic par,
                               input int sb);
        int pos;
        pos = base;
        check_slot({tag, "_start"}, q, pos, 16, 1'b0);
        pos += 16;
        for (int i = 0; i < 8; i++) begin
            check_slot($sformatf("%s_d%0d", tag, i), q, pos, 16, data[i]);
            pos += 16;
        end
        if (par_en) begin
            check_slot({tag, "_par"}, q, pos, 16, par);
            pos += 16;
        end
        check_slot({tag, "_stop"}, q, pos, sb, 1'b1);
    endtask

    // Returns at the negedge of the cycle in which the chosen instance pulses done.
    task automatic wait_done(input int which, input int budget, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            case (which)
                0:       got = done0;
                1:       got = done1;
                default: got = done3;
            endcase
        end
        check1({tag, "_done_seen"}, got, 1'b1);
    endtask

    initial begin
        int n;
        int k;
        rst = 1'b1;
        tick_hi = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        din0 = 8'h00; din1 = 8'h00; din3 = 8'h00;
        step(3);
        check1("rst_tx", tx0, 1'b1);
        check1("rst_busy", busy0, 1'b0);
        check1("rst_baud_en", ben0, 1'b0);
        check1("rst_done", done0, 1'b0);
        check1("rst_tx_sb32", tx3, 1'b1);
        check1("rst_busy_par", busy1, 1'b0);
        rst = 1'b0;
        step(2);

        // 1: plain 8N1 frame
        samp0.delete();
        din0 = 8'hA5; start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        check1("t1_tx_start", tx0, 1'b0);
        check1("t1_busy", busy0, 1'b1);
        check1("t1_baud_en", ben0, 1'b1);
        wait_done(0, 900, "t1");
        check1("t1_done_busy", busy0, 1'b0);
        check1("t1_done_baud_en", ben0, 1'b0);
        step(1);
        check1("t1_pulse_end", done0, 1'b0);
        check1("t1_idle_tx", tx0, 1'b1);
        step(1);
        checkn("t1_len", samp0.size(), 160);
        check_frame("t1", samp0, 0, 8'hA5, 1'b0, 1'b0, 16);
        checkn("t1_ndone", done_cnt0, 1);

        // 2: even and odd parity on 8'h07
        samp1.delete(); samp2.delete();
        din1 = 8'h07; start1 = 1'b1;
        step(1);
        start1 = 1'b0; din1 = 8'hFF;
        wait_done(1, 1000, "t2");
        step(2);
        checkn("t2_len_even", samp1.size(), 176);
        checkn("t2_len_odd", samp2.size(), 176);
        check_frame("t2_even", samp1, 0, 8'h07, 1'b1, 1'b1, 16);
        check_frame("t2_odd", samp2, 0, 8'h07, 1'b1, 1'b0, 16);
        checkn("t2_ndone_odd", done_cnt2, 1);

        // 3: tx_start during DATA is ignored
        samp0.delete();
        n = done_cnt0;
        din0 = 8'hFF; start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(100);
        din0 = 8'h3C; start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        wait_done(0, 900, "t3");
        step(2);
        checkn("t3_len", samp0.size(), 160);
        check_frame("t3", samp0, 0, 8'hFF, 1'b0, 1'b0, 16);
        step(40);
        checkn("t3_ndone", done_cnt0 - n, 1);
        check1("t3_idle", busy0, 1'b0);

        // 4: start held through the done cycle gives a back-to-back frame
        samp0.delete();
        din0 = 8'hC3; start0 = 1'b1;
        step(1);
        din0 = 8'h5A;
        wait_done(0, 900, "t4a");
        step(1);
        check1("t4_b2b_tx", tx0, 1'b0);
        check1("t4_b2b_busy", busy0, 1'b1);
        start0 = 1'b0;
        wait_done(0, 900, "t4b");
        step(2);
        k = done_ticks0.size();
        checkn("t4_gap", done_ticks0[k-1] - done_ticks0[k-2], 160);
        checkn("t4_len", samp0.size(), 320);
        check_frame("t4_f1", samp0, 0, 8'hC3, 1'b0, 1'b0, 16);
        check_frame("t4_f2", samp0, 160, 8'h5A, 1'b0, 1'b0, 16);

        // 5: reset mid-frame at data bit 3
        n = done_cnt0;
        din0 = 8'h96; start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(287);
        check1("t5_midframe", busy0, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check1("t5_tx", tx0, 1'b1);
        check1("t5_busy", busy0, 1'b0);
        check1("t5_baud_en", ben0, 1'b0);
        step(300);
        checkn("t5_no_done", done_cnt0 - n, 0);
        check1("t5_still_idle", tx0, 1'b1);
        samp0.delete();
        din0 = 8'h69; start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        wait_done(0, 900, "t5");
        step(2);
        checkn("t5_len", samp0.size(), 160);
        check_frame("t5", samp0, 0, 8'h69, 1'b0, 1'b0, 16);

        // 6: two stop bits, tick every cycle
        samp3.delete();
        din3 = 8'h6B; start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        wait_done(3, 400, "t6");
        step(2);
        checkn("t6_len", samp3.size(), 176);
        check_frame("t6", samp3, 0, 8'h6B, 1'b0, 1'b0, 32);
        checkn("t6_ndone", done_cnt3, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
